// File: rtl/instr_mem_loader_if.sv
// rtl/instr_mem_loader_if.sv - program load stream between a word source and the instruction memory loader
interface instr_mem_loader_if #(
  parameter int DATA_W = 32
);
  logic              load_start;
  logic [31:0]       load_base;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic              load_done;
  logic              load_err;

  modport master (
    output load_start, load_base, load_valid, load_data, load_last,
    input  load_ready, load_done, load_err
  );

  modport slave (
    input  load_start, load_base, load_valid, load_data, load_last,
    output load_ready, load_done, load_err
  );
endinterface

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - instruction memory that self-clears after reset and accepts streamed program loads
module instr_mem_loader #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 256,
  parameter int REG_READ = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         PC,
  output logic [DATA_W-1:0]   instruction,
  output logic                fetch_err,
  output logic                misalign,
  output logic                busy,
  instr_mem_loader_if.slave   load_if
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     clr_ptr_q, clr_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic              load_err_q, load_err_d;
  logic              load_done_q, load_done_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic              xfer;
  logic              base_in_range;
  logic [AW-1:0]     base_idx;
  logic              base_unused;

  assign base_idx      = load_if.load_base[AW+1:2];
  assign base_in_range = ~|load_if.load_base[31:AW+2];
  assign base_unused   = ^load_if.load_base[1:0];
  assign xfer          = load_if.load_valid && (state_q == LOAD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR;
      clr_ptr_q   <= '0;
      wr_ptr_q    <= '0;
      load_err_q  <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      load_err_q  <= load_err_d;
      load_done_q <= load_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    load_err_d  = load_err_q;
    load_done_d = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = clr_ptr_q;
    mem_wdata   = '0;
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == LAST_IDX) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (load_if.load_start) begin
          if (base_in_range) begin
            wr_ptr_d   = base_idx;
            load_err_d = 1'b0;
            state_d    = LOAD;
          end else begin
            load_err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (xfer) begin
          mem_we    = 1'b1;
          mem_waddr = wr_ptr_q;
          mem_wdata = load_if.load_data;
          wr_ptr_d  = wr_ptr_q + 1'b1;
          if (load_if.load_last) begin
            load_done_d = 1'b1;
            state_d     = RUN;
          end else if (wr_ptr_q == LAST_IDX) begin
            // Stream ran off the end of memory: keep the last word, flag it, no wrap.
            load_err_d = 1'b1;
            state_d    = RUN;
          end
        end
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  // Reset wins over any write in flight, including a clear or load transfer.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign busy               = (state_q != RUN);
  assign load_if.load_ready = (state_q == LOAD);
  assign load_if.load_done  = load_done_q;
  assign load_if.load_err   = load_err_q;

  logic [AW-1:0]     fetch_idx;
  logic              fetch_err_c;
  logic              misalign_c;
  logic [DATA_W-1:0] instr_c;

  assign fetch_idx   = PC[AW+1:2];
  assign fetch_err_c = |PC[31:AW+2];
  assign misalign_c  = |PC[1:0];
  assign instr_c     = (busy || fetch_err_c) ? '0 : mem_q[fetch_idx];

  if (REG_READ != 0) begin : g_reg_read
    logic [DATA_W-1:0] instr_q;
    logic              fetch_err_q;
    logic              misalign_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        instr_q     <= '0;
        fetch_err_q <= 1'b0;
        misalign_q  <= 1'b0;
      end else begin
        instr_q     <= instr_c;
        fetch_err_q <= fetch_err_c;
        misalign_q  <= misalign_c;
      end
    end

    assign instruction = instr_q;
    assign fetch_err   = fetch_err_q;
    assign misalign    = misalign_q;
  end else begin : g_comb_read
    assign instruction = instr_c;
    assign fetch_err   = fetch_err_c;
    assign misalign    = misalign_c;
  end

endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 32, instruction word width.
REQ-002 SHALL have parameter DEPTH, default 256, number of words; power of two, minimum 4.
REQ-003 SHALL have parameter REG_READ, default 0; 0 gives a combinational fetch, 1 gives a registered fetch.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have port PC, input, 32 bits, byte address of the fetch.
REQ-007 SHALL have port instruction, output, DATA_W bits, the fetched word.
REQ-008 SHALL have port fetch_err, output, 1 bit: PC is out of range.
REQ-009 SHALL have port misalign, output, 1 bit: PC[1:0] is not 0.
REQ-010 SHALL have port busy, output, 1 bit: memory is clearing or loading.
REQ-011 SHALL have port load_start, input, 1 bit: single-cycle request to begin a load.
REQ-012 SHALL have port load_base, input, 32 bits, byte address of the first word loaded.
REQ-013 SHALL have port load_valid, input, 1 bit: load_data is valid.
REQ-014 SHALL have port load_data, input, DATA_W bits, program word.
REQ-015 SHALL have port load_last, input, 1 bit: current word is the final word.
REQ-016 SHALL have port load_ready, output, 1 bit: loader accepts a word this cycle.
REQ-017 SHALL have port load_done, output, 1 bit: single-cycle pulse when a load completes.
REQ-018 SHALL have port load_err, output, 1 bit, sticky load-failure flag.

Function
REQ-019 SHALL implement states CLEAR, RUN and LOAD.
REQ-020 SHALL, in CLEAR, write 0 to word clr_ptr each cycle, starting at 0 and incrementing; after writing word DEPTH-1 the next state SHALL be RUN.
REQ-021 SHALL hold busy=1 in CLEAR and LOAD, and busy=0 in RUN.
REQ-022 SHALL compute fetch index idx = PC>>2; fetch_err=1 when idx >= DEPTH.
REQ-023 SHALL set misalign = (PC[1:0] != 0); fetch still uses idx, and misalign does not block the fetch.
REQ-024 SHALL drive instruction = 0 (NOP) when busy=1 or fetch_err=1; otherwise instruction = mem[idx].
REQ-025 SHALL, with REG_READ=0, make instruction, fetch_err and misalign combinational in PC and state.
REQ-026 SHALL, with REG_READ=1, register instruction, fetch_err and misalign, giving 1-cycle latency from PC.
REQ-027 SHALL, on load_start in RUN with (load_base>>2) < DEPTH, capture wr_ptr = load_base>>2, clear load_err, and enter LOAD next cycle.
REQ-028 SHALL, on load_start in RUN with (load_base>>2) >= DEPTH, set load_err=1 and remain in RUN.
REQ-029 SHALL ignore load_start in CLEAR and LOAD.
REQ-030 SHALL assert load_ready=1 only in LOAD; a word transfers when load_valid & load_ready.
REQ-031 SHALL, on each transfer, write load_data to mem[wr_ptr] and increment wr_ptr.
REQ-032 SHALL, on a transfer with load_last=1, enter RUN next cycle and pulse load_done for exactly 1 cycle.
REQ-033 SHALL, on a transfer with load_last=0 at wr_ptr = DEPTH-1, write the word, set load_err=1, enter RUN, and not pulse load_done; there is no wrap to 0.
REQ-034 SHALL insert no bubbles while load_valid is held high: 1 word per cycle.
REQ-035 SHALL let fetches in RUN see words written by completed loads on the next cycle.

Reset
REQ-036 SHALL, when rst=1, force state CLEAR, clr_ptr=0, wr_ptr=0, load_ready=0, load_done=0, load_err=0, and the instruction register (REG_READ=1) to 0.
REQ-037 SHALL give rst priority over every other event, including a transfer in flight; a partial load is abandoned and memory is re-cleared.
REQ-038 SHALL hold busy=1 from the first cycle after rst deasserts for exactly DEPTH cycles.

Verification (DEPTH=16)
REQ-039 SHALL cover: rst 1 cycle then PC=0 -> busy=1 and instruction=0 for 16 cycles, then busy=0 and instruction=0x00000000.
REQ-040 SHALL cover: load_start with load_base=0x8, then words 0xA,0xB,0xC with load_last on 0xC -> load_done 1 cycle; PC=0x8/0xC/0x10 read 0xA/0xB/0xC (same cycle with REG_READ=0, next cycle with REG_READ=1).
REQ-041 SHALL cover: load_base=0x3C, then 2 words with load_last=0 -> load_err=1 after word 1, mem[15] = word 1, load_ready=0 next cycle.
REQ-042 SHALL cover: load_base=0x40 -> load_err=1 with no LOAD entry; PC=0x40 -> fetch_err=1 and instruction=0.
REQ-043 SHALL cover: PC=0x9 -> misalign=1 and instruction=mem[2].
REQ-044 SHALL cover: rst asserted mid-load after 2 words -> CLEAR restarts and all words read 0 after 16 cycles.
